pipe_sel_stage: RTL
===================

PIPE_SEL_STAGE -- requirements
Module: pipe_sel_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per input channel.
REQ-002 SHALL have parameter NUM_IN, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL derive localparam SEL_W = clog2(NUM_IN), select width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel select, sampled with in_valid.
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_ready  output  1  stage accepts beat this cycle.
REQ-010 flush  input  1  synchronous discard of all held beats.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_sel_err  output  1  held beat was captured with sel >= NUM_IN.
REQ-013 out_valid  output  1  held beat present.
REQ-014 out_ready  input  1  downstream accepts beat.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 On input transfer, SHALL capture in_data channel sel into the stage; latency in_valid -> out_valid exactly 1 cycle when stage empty.
REQ-017 If sel >= NUM_IN at capture, SHALL capture all-zero data and set out_sel_err with that beat; error travels with beat, not sticky.
REQ-018 out_data/out_sel_err SHALL stay stable while out_valid && !out_ready.
REQ-019 Without skid (see REQ-026): in_ready = !out_valid || out_ready (combinational pass-through of out_ready); simultaneous in/out transfer SHALL replace the held beat, no bubble.
REQ-020 Beat order SHALL be preserved; no beat duplicated or dropped except by flush.
REQ-021 flush SHALL clear out_valid (and skid entry) next edge, takes priority over a same-cycle input transfer (that beat discarded); in_ready SHALL be 0 while flush is high.
REQ-022 in_valid must not drop without transfer; stage SHALL NOT rely on this (no lockup if violated).

Reset
REQ-023 rst low SHALL asynchronously clear out_valid, out_sel_err, skid valid to 0 and out_data to 0.
REQ-024 in_ready SHALL be 1 during reset deassert-to-first-edge (stage empty); reset mid-transfer SHALL discard all beats.
REQ-025 Reset release SHALL be synchronised externally; no internal reset synchroniser.

Configuration
REQ-026 Macro PIPE_SEL_SKID_EN: defined -> two-entry skid buffer; in_ready is a registered signal = !skid_valid, independent of out_ready combinationally; beat arriving while out stalled goes to skid, promoted to output on next output transfer; full throughput sustained.
REQ-027 PIPE_SEL_SKID_EN undefined -> single register per REQ-019, no skid storage synthesised.
REQ-028 Both builds SHALL give identical beat sequences for identical accepted inputs.

Structure
REQ-029 Shared package pipe_pkg SHALL hold clog2 function, default WIDTH/NUM_IN constants, and beat struct/field offsets {data, sel_err}.
REQ-030 Channel selection SHALL be a sub-module mux_n (parametrised combinational NUM_IN:1, WIDTH-wide, zero + err on out-of-range), the generalisation of the existing 2:1 mux.
REQ-031 Top holds only handshake/storage; no latches; single always block per register group.

Verification
REQ-032 Reset: rst low mid-stream with out_valid=1 -> out_valid=0, out_data=0 immediately (before clock edge).
REQ-033 Select sweep: NUM_IN=4, in_data={32'hDDDD,32'hCCCC,32'hBBBB,32'hAAAA}, sel=0..3 back-to-back, out_ready=1 -> out_data AAAA,BBBB,CCCC,DDDD on consecutive cycles, 1-cycle latency.
REQ-034 Out-of-range: NUM_IN=3, sel=3 -> out_data=0, out_sel_err=1 for that beat only; next beat sel=1 -> err=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> data stable; without skid in_ready=0 after 1 beat held; with skid after 2; release -> all beats in order, none lost.
REQ-036 Flush: flush=1 with held beat and same-cycle input transfer -> out_valid=0 next cycle, neither beat emitted.
REQ-037 Random: random valid/ready/sel/flush 10k cycles, both macro builds, scoreboard confirms order and data.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, select-width helper and beat layout for the
// pipe_sel_stage slice.
//   DEF_WIDTH / DEF_NUM_IN : default channel width and channel count
//   clog2()                : select width for a channel count (minimum 1)
//   beat_t, BEAT_*_OFS     : held beat = {data, sel_err}, sel_err in bit 0
package pipe_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NUM_IN = 4;

  // Field offsets of a beat flattened into a WIDTH+1 vector.
  localparam int unsigned BEAT_ERR_OFS  = 0;
  localparam int unsigned BEAT_DATA_OFS = 1;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 sel_err;
  } beat_t;

  // Ceiling log2, never below 1 so a 2:1 select still has one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_sel_stage_mux_n.sv
// mux_n: combinational NUM_IN:1 channel select, WIDTH bits per channel.
// An out-of-range select yields all-zero data with sel_err_c set.
// Ports:
//   in_data   [NUM_IN*WIDTH] packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel       [SEL_W]        channel index
//   data_c    [WIDTH]        selected channel (combinational)
//   sel_err_c                sel >= NUM_IN (combinational)
module mux_n
  import pipe_pkg::*;
#(
  parameter int unsigned  WIDTH  = DEF_WIDTH,
  parameter int unsigned  NUM_IN = DEF_NUM_IN,
  localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data_c,
  output logic                    sel_err_c
);

  // Unmatched select falls through to the zero/error defaults.
  always_comb begin
    data_c    = '0;
    sel_err_c = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data_c    = in_data[k*WIDTH +: WIDTH];
        sel_err_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_sel_stage.sv
// pipe_sel_stage: valid/ready pipeline stage that captures one selected
// input channel per accepted beat.
// Build option: PIPE_SEL_SKID_EN adds a second (skid) entry so in_ready is
// a register output and full throughput holds under output stalls; without
// it the stage is a single register with in_ready passing out_ready through.
// Ports:
//   clk, rst (async, active-low)
//   in_data [NUM_IN*WIDTH], sel [SEL_W], in_valid -> in_ready
//   flush        synchronous discard of every held beat
//   out_data [WIDTH], out_sel_err, out_valid <- out_ready
module pipe_sel_stage
  import pipe_pkg::*;
#(
  parameter int unsigned  WIDTH  = DEF_WIDTH,
  parameter int unsigned  NUM_IN = DEF_NUM_IN,
  localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned BEAT_W = WIDTH + 1;

  logic [WIDTH-1:0]  mux_data;
  logic              mux_err;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat;
  logic              in_xfer;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data   (in_data),
    .sel       (sel),
    .data_c    (mux_data),
    .sel_err_c (mux_err)
  );

  assign in_beat     = {mux_data, mux_err};
  assign in_xfer     = in_valid && in_ready;
  assign out_data    = out_beat[BEAT_DATA_OFS +: WIDTH];
  assign out_sel_err = out_beat[BEAT_ERR_OFS];

`ifdef PIPE_SEL_SKID_EN

  logic              skid_valid;
  logic [BEAT_W-1:0] skid_beat;
  logic              out_free;

  // Skid register gates acceptance, so in_ready never depends on out_ready.
  assign in_ready = !skid_valid && !flush;
  assign out_free = !out_valid || out_ready;

  // Occupancy: skid only fills while the output slot is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid  <= in_xfer;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload: skid entry is older than any new beat, so it is promoted first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_beat  <= '0;
      skid_beat <= '0;
    end else if (!flush) begin
      if (out_free) begin
        if (skid_valid) out_beat <= skid_beat;
        else if (in_xfer) out_beat <= in_beat;
      end else if (in_xfer) begin
        skid_beat <= in_beat;
      end
    end
  end

`else

  logic out_xfer;

  // Accept whenever the held beat is absent or leaving this cycle.
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // in_xfer is already suppressed by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_beat <= '0;
    end else if (in_xfer) begin
      out_beat <= in_beat;
    end
  end

`endif

endmodule
